// File: rtl/wb_axi_write_arbiter.sv
// Two-master to one-slave AXI4 write-channel arbiter: one whole AW/W/B transaction at a time,
// round-robin on ties (fixed priority to master 0 when WB_ARB_FIXED_PRIO_EN is defined).
module wb_axi_write_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,

  input  logic [ADDR_W-1:0]   s0_awaddr,
  input  logic [7:0]          s0_awlen,
  input  logic [2:0]          s0_awsize,
  input  logic [1:0]          s0_awburst,
  input  logic [3:0]          s0_awcache,
  input  logic                s0_awlock,
  input  logic [2:0]          s0_awprot,
  input  logic                s0_awvalid,
  output logic                s0_awready,
  input  logic [DATA_W-1:0]   s0_wdata,
  input  logic [DATA_W/8-1:0] s0_wstrb,
  input  logic                s0_wlast,
  input  logic                s0_wvalid,
  output logic                s0_wready,
  output logic [1:0]          s0_bresp,
  output logic                s0_bvalid,
  input  logic                s0_bready,

  input  logic [ADDR_W-1:0]   s1_awaddr,
  input  logic [7:0]          s1_awlen,
  input  logic [2:0]          s1_awsize,
  input  logic [1:0]          s1_awburst,
  input  logic [3:0]          s1_awcache,
  input  logic                s1_awlock,
  input  logic [2:0]          s1_awprot,
  input  logic                s1_awvalid,
  output logic                s1_awready,
  input  logic [DATA_W-1:0]   s1_wdata,
  input  logic [DATA_W/8-1:0] s1_wstrb,
  input  logic                s1_wlast,
  input  logic                s1_wvalid,
  output logic                s1_wready,
  output logic [1:0]          s1_bresp,
  output logic                s1_bvalid,
  input  logic                s1_bready,

  output logic [ADDR_W-1:0]   m_awaddr,
  output logic [7:0]          m_awlen,
  output logic [2:0]          m_awsize,
  output logic [1:0]          m_awburst,
  output logic [3:0]          m_awcache,
  output logic                m_awlock,
  output logic [2:0]          m_awprot,
  output logic                m_awvalid,
  input  logic                m_awready,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  output logic                m_wlast,
  output logic                m_wvalid,
  input  logic                m_wready,
  input  logic [1:0]          m_bresp,
  input  logic                m_bvalid,
  output logic                m_bready,

  output logic                grant,
  output logic                busy,
  output logic                err_wlast
);

  typedef enum logic [1:0] {IDLE, DATA, RESP} state_e;

  state_e      state_q, state_d;
  logic        grant_q, grant_d;
  logic        last_grant_q, last_grant_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic [7:0]  beat_cnt_q, beat_cnt_d;
  logic [7:0]  awlen_q, awlen_d;
  logic        err_q, err_d;

  logic [ADDR_W-1:0]   sel_awaddr;
  logic [7:0]          sel_awlen;
  logic [2:0]          sel_awsize;
  logic [1:0]          sel_awburst;
  logic [3:0]          sel_awcache;
  logic                sel_awlock;
  logic [2:0]          sel_awprot;
  logic                sel_awvalid;
  logic [DATA_W-1:0]   sel_wdata;
  logic [DATA_W/8-1:0] sel_wstrb;
  logic                sel_wlast;
  logic                sel_wvalid;
  logic                sel_bready;

  logic in_data, in_resp;
  logic aw_hs, w_hs, b_hs;
  logic aw_rdy_g, w_rdy_g, b_vld_g;
  logic [7:0] cur_awlen;
  logic win;

  always_comb begin
    sel_awaddr  = grant_q ? s1_awaddr  : s0_awaddr;
    sel_awlen   = grant_q ? s1_awlen   : s0_awlen;
    sel_awsize  = grant_q ? s1_awsize  : s0_awsize;
    sel_awburst = grant_q ? s1_awburst : s0_awburst;
    sel_awcache = grant_q ? s1_awcache : s0_awcache;
    sel_awlock  = grant_q ? s1_awlock  : s0_awlock;
    sel_awprot  = grant_q ? s1_awprot  : s0_awprot;
    sel_awvalid = grant_q ? s1_awvalid : s0_awvalid;
    sel_wdata   = grant_q ? s1_wdata   : s0_wdata;
    sel_wstrb   = grant_q ? s1_wstrb   : s0_wstrb;
    sel_wlast   = grant_q ? s1_wlast   : s0_wlast;
    sel_wvalid  = grant_q ? s1_wvalid  : s0_wvalid;
    sel_bready  = grant_q ? s1_bready  : s0_bready;
  end

  assign in_data = (state_q == DATA);
  assign in_resp = (state_q == RESP);

  // Outside DATA the slave sees an all-zero request, so stale master fields never leak out.
  assign m_awaddr  = in_data ? sel_awaddr  : '0;
  assign m_awlen   = in_data ? sel_awlen   : '0;
  assign m_awsize  = in_data ? sel_awsize  : '0;
  assign m_awburst = in_data ? sel_awburst : '0;
  assign m_awcache = in_data ? sel_awcache : '0;
  assign m_awlock  = in_data & sel_awlock;
  assign m_awprot  = in_data ? sel_awprot  : '0;
  assign m_awvalid = in_data & ~aw_done_q & sel_awvalid;
  assign m_wdata   = in_data ? sel_wdata   : '0;
  assign m_wstrb   = in_data ? sel_wstrb   : '0;
  assign m_wlast   = in_data & sel_wlast;
  assign m_wvalid  = in_data & ~w_done_q & sel_wvalid;
  assign m_bready  = in_resp & sel_bready;

  assign aw_rdy_g = in_data & ~aw_done_q & m_awready;
  assign w_rdy_g  = in_data & ~w_done_q & m_wready;
  assign b_vld_g  = in_resp & m_bvalid;

  assign s0_awready = aw_rdy_g & ~grant_q;
  assign s1_awready = aw_rdy_g &  grant_q;
  assign s0_wready  = w_rdy_g  & ~grant_q;
  assign s1_wready  = w_rdy_g  &  grant_q;
  assign s0_bvalid  = b_vld_g  & ~grant_q;
  assign s1_bvalid  = b_vld_g  &  grant_q;
  assign s0_bresp   = (in_resp & ~grant_q) ? m_bresp : 2'b00;
  assign s1_bresp   = (in_resp &  grant_q) ? m_bresp : 2'b00;

  assign aw_hs = m_awvalid & m_awready;
  assign w_hs  = m_wvalid & m_wready;
  assign b_hs  = m_bvalid & m_bready;

  // Before the AW handshake the master's live awlen is the only length available.
  assign cur_awlen = aw_done_q ? awlen_q : sel_awlen;

  assign grant     = grant_q;
  assign busy      = (state_q != IDLE);
  assign err_wlast = err_q;

  always_comb begin
`ifdef WB_ARB_FIXED_PRIO_EN
    win = ~s0_awvalid;
`else
    win = (s0_awvalid & s1_awvalid) ? ~last_grant_q : s1_awvalid;
`endif
  end

  // NOTE: every next-state signal is defaulted to its register first so no path infers a latch.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    beat_cnt_d   = beat_cnt_q;
    awlen_d      = awlen_q;
    err_d        = err_q;
    unique case (state_q)
      IDLE: begin
        if (s0_awvalid | s1_awvalid) begin
          grant_d = win;
          state_d = DATA;
        end
      end
      DATA: begin
        if (aw_hs) begin
          aw_done_d = 1'b1;
          awlen_d   = sel_awlen;
        end
        if (w_hs) begin
          beat_cnt_d = beat_cnt_q + 8'd1;
          if (sel_wlast) begin
            w_done_d = 1'b1;
            if (beat_cnt_q != cur_awlen) err_d = 1'b1;
          end else if (beat_cnt_q == cur_awlen) begin
            err_d = 1'b1;
          end
        end
        if (aw_done_d & w_done_d) state_d = RESP;
      end
      RESP: begin
        if (b_hs) begin
          last_grant_d = grant_q;
          aw_done_d    = 1'b0;
          w_done_d     = 1'b0;
          beat_cnt_d   = 8'd0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      beat_cnt_q   <= 8'd0;
      awlen_q      <= 8'd0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
      beat_cnt_q   <= beat_cnt_d;
      awlen_q      <= awlen_d;
      err_q        <= err_d;
    end
  end

endmodule

// File: tb/tb_wb_axi_write_arbiter.sv
// Bench for wb_axi_write_arbiter: two driven masters, a randomly stalling memory slave,
// and a reference model of grant order and memory contents.
`define CHK(tag, o, e) check(tag, 64'(o), 64'(e))

module tb_wb_axi_write_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [11:0] s_awaddr [2];
  logic [7:0]  s_awlen  [2];
  logic [2:0]  s_awsize [2];
  logic [1:0]  s_awburst[2];
  logic [3:0]  s_awcache[2];
  logic        s_awlock [2];
  logic [2:0]  s_awprot [2];
  logic        s_awvalid[2];
  logic        s_awready[2];
  logic [31:0] s_wdata  [2];
  logic [3:0]  s_wstrb  [2];
  logic        s_wlast  [2];
  logic        s_wvalid [2];
  logic        s_wready [2];
  logic [1:0]  s_bresp  [2];
  logic        s_bvalid [2];
  logic        s_bready [2];

  logic [11:0] m_awaddr;
  logic [7:0]  m_awlen;
  logic [2:0]  m_awsize;
  logic [1:0]  m_awburst;
  logic [3:0]  m_awcache;
  logic        m_awlock;
  logic [2:0]  m_awprot;
  logic        m_awvalid, m_awready;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic        m_wlast, m_wvalid, m_wready;
  logic [1:0]  m_bresp;
  logic        m_bvalid, m_bready;
  logic        grant, busy, err_wlast;

  wb_axi_write_arbiter #(.ADDR_W(12), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .s0_awaddr(s_awaddr[0]), .s0_awlen(s_awlen[0]), .s0_awsize(s_awsize[0]),
    .s0_awburst(s_awburst[0]), .s0_awcache(s_awcache[0]), .s0_awlock(s_awlock[0]),
    .s0_awprot(s_awprot[0]), .s0_awvalid(s_awvalid[0]), .s0_awready(s_awready[0]),
    .s0_wdata(s_wdata[0]), .s0_wstrb(s_wstrb[0]), .s0_wlast(s_wlast[0]),
    .s0_wvalid(s_wvalid[0]), .s0_wready(s_wready[0]),
    .s0_bresp(s_bresp[0]), .s0_bvalid(s_bvalid[0]), .s0_bready(s_bready[0]),
    .s1_awaddr(s_awaddr[1]), .s1_awlen(s_awlen[1]), .s1_awsize(s_awsize[1]),
    .s1_awburst(s_awburst[1]), .s1_awcache(s_awcache[1]), .s1_awlock(s_awlock[1]),
    .s1_awprot(s_awprot[1]), .s1_awvalid(s_awvalid[1]), .s1_awready(s_awready[1]),
    .s1_wdata(s_wdata[1]), .s1_wstrb(s_wstrb[1]), .s1_wlast(s_wlast[1]),
    .s1_wvalid(s_wvalid[1]), .s1_wready(s_wready[1]),
    .s1_bresp(s_bresp[1]), .s1_bvalid(s_bvalid[1]), .s1_bready(s_bready[1]),
    .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
    .m_awcache(m_awcache), .m_awlock(m_awlock), .m_awprot(m_awprot),
    .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .grant(grant), .busy(busy), .err_wlast(err_wlast)
  );

  int tests = 0;
  int fails = 0;
  bit exp_last;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Memory slave: readies change on the falling edge, handshakes are recorded 2 ns later.
  logic [31:0] mem     [4096];
  logic [31:0] exp_mem [4096];
  logic [31:0] wq[$];
  bit          aw_seen, wl_seen, b_drop, aw_late;
  logic [11:0] cap_addr;
  logic [7:0]  cap_len;
  logic [3:0]  cap_cache;
  int          cap_beats;
  logic [1:0]  exp_bresp;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_bresp = 2'b00;
      aw_seen = 1'b0; wl_seen = 1'b0; b_drop = 1'b0;
      wq.delete();
    end else begin
      if (b_drop) begin m_bvalid = 1'b0; b_drop = 1'b0; end
      m_awready = !aw_seen && (aw_late ? wl_seen : ($urandom_range(0, 2) != 0));
      m_wready  = !wl_seen && ($urandom_range(0, 3) != 0);
      if (!m_bvalid && aw_seen && wl_seen) begin
        m_bvalid  = 1'b1;
        m_bresp   = 2'($urandom_range(0, 3));
        exp_bresp = m_bresp;
      end
      #2;
      if (m_awvalid && m_awready) begin
        aw_seen = 1'b1; cap_addr = m_awaddr; cap_len = m_awlen; cap_cache = m_awcache;
      end
      if (m_wvalid && m_wready) begin
        wq.push_back(m_wdata);
        if (m_wlast) wl_seen = 1'b1;
      end
      if (m_bvalid && m_bready) begin
        foreach (wq[i]) mem[cap_addr + 12'(i)] = wq[i];
        cap_beats = wq.size();
        wq.delete();
        aw_seen = 1'b0; wl_seen = 1'b0; b_drop = 1'b1;
      end
    end
  end

  function automatic bit exp_win();
`ifdef WB_ARB_FIXED_PRIO_EN
    return 1'b0;
`else
    return ~exp_last;
`endif
  endfunction

  task automatic arm(input bit m, input logic [11:0] addr, input logic [7:0] len);
    s_awaddr[m] = addr; s_awlen[m] = len; s_awsize[m] = 3'd2; s_awburst[m] = 2'b01;
    s_awcache[m] = addr[3:0]; s_awlock[m] = 1'b0; s_awprot[m] = addr[2:0];
    s_awvalid[m] = 1'b1;
  endtask

  // One full write from master m, called on a falling edge; returns on a falling edge.
  task automatic xact(input bit m, input logic [11:0] addr, input int nbeats,
                      input logic [7:0] len, input logic [31:0] base, input int w_lead,
                      input bit chk_lat, input int abort_at);
    int beat = 0;
    int cyc;
    int bad_mem = 0;
    bit o = ~m;
    bit aw_d = 0, aw_hs, w_hs, grant_bad = 0, other_bad = 0, got = 0;
    logic [1:0] rb;
    s_wdata[m] = base; s_wstrb[m] = 4'hF; s_wlast[m] = (nbeats == 1);
    if (w_lead > 0) begin
      s_wvalid[m] = 1'b1;
      repeat (w_lead) @(negedge clk);
    end else begin
      s_wvalid[m] = ($urandom_range(0, 1) == 1);
    end
    arm(m, addr, len);
    for (cyc = 0; cyc < 3000 && !(aw_d && beat == nbeats); cyc++) begin
      #2;
      if (chk_lat && cyc == 0) begin
        `CHK("lat_idle_busy", busy, 0);
        `CHK("lat_idle_awvalid", m_awvalid, 0);
      end
      if (chk_lat && cyc == 1) begin
        `CHK("lat_busy", busy, 1);
        `CHK("lat_awvalid", m_awvalid, 1);
        `CHK("lat_grant", grant, m);
      end
      if (busy && grant !== m) grant_bad = 1;
      if ((s_awready[o] | s_wready[o] | s_bvalid[o]) !== 1'b0) other_bad = 1;
      aw_hs = s_awvalid[m] && s_awready[m];
      w_hs  = s_wvalid[m] && s_wready[m];
      @(negedge clk);
      if (aw_hs) begin s_awvalid[m] = 1'b0; aw_d = 1; end
      if (w_hs) begin
        beat++;
        s_wdata[m] = base + 32'(beat);
        s_wlast[m] = (beat == nbeats - 1);
      end
      if (beat >= nbeats) s_wvalid[m] = 1'b0;
      else if (w_hs || !s_wvalid[m]) s_wvalid[m] = ($urandom_range(0, 3) != 0);
      if (abort_at >= 0 && beat >= abort_at) begin
        rst_n = 1'b0; s_awvalid[m] = 1'b0; s_wvalid[m] = 1'b0;
        return;
      end
    end
    `CHK("data_phase_done", aw_d && beat == nbeats, 1);
    for (cyc = 0; cyc < 3000 && !got; cyc++) begin
      s_bready[m] = ($urandom_range(0, 2) != 0);
      #2;
      if (busy && grant !== m) grant_bad = 1;
      if ((s_awready[o] | s_wready[o] | s_bvalid[o]) !== 1'b0) other_bad = 1;
      if (s_bvalid[m] && s_bready[m]) begin got = 1; rb = s_bresp[m]; end
      @(negedge clk);
    end
    s_bready[m] = 1'b0;
    `CHK("b_done", got, 1);
    `CHK("bresp", rb, exp_bresp);
    `CHK("grant_hold", grant_bad, 0);
    `CHK("other_quiet", other_bad, 0);
    #2;
    `CHK("busy_after_b", busy, 0);
    `CHK("slave_awaddr", cap_addr, addr);
    `CHK("slave_awlen", cap_len, len);
    `CHK("slave_awcache", cap_cache, addr[3:0]);
    `CHK("slave_beats", cap_beats, nbeats);
    for (int i = 0; i < nbeats; i++) exp_mem[addr + 12'(i)] = base + 32'(i);
    for (int i = 0; i < nbeats; i++)
      if (mem[addr + 12'(i)] !== exp_mem[addr + 12'(i)]) bad_mem++;
    `CHK("mem_words_bad", bad_mem, 0);
    exp_last = m;
    @(negedge clk);
  endtask

  task automatic tie_pair(input logic [11:0] a0, input int n0, input logic [11:0] a1, input int n1);
    bit w;
    arm(1'b0, a0, 8'(n0 - 1));
    arm(1'b1, a1, 8'(n1 - 1));
    w = exp_win();
    if (!w) begin
      xact(1'b0, a0, n0, 8'(n0 - 1), $urandom, 0, 0, -1);
      xact(1'b1, a1, n1, 8'(n1 - 1), $urandom, 0, 0, -1);
    end else begin
      xact(1'b1, a1, n1, 8'(n1 - 1), $urandom, 0, 0, -1);
      xact(1'b0, a0, n0, 8'(n0 - 1), $urandom, 0, 0, -1);
    end
  endtask

  bit          mm, tie_sel;
  int          n, n2;
  logic [11:0] a, a2;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4096; i++) begin mem[i] = '0; exp_mem[i] = '0; end
    for (int m = 0; m < 2; m++) begin
      s_awaddr[m] = '0; s_awlen[m] = '0; s_awsize[m] = '0; s_awburst[m] = '0;
      s_awcache[m] = '0; s_awlock[m] = 1'b0; s_awprot[m] = '0; s_awvalid[m] = 1'b0;
      s_wdata[m] = '0; s_wstrb[m] = '0; s_wlast[m] = 1'b0; s_wvalid[m] = 1'b0;
      s_bready[m] = 1'b0;
    end
    aw_late = 1'b0;
    exp_last = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    `CHK("rst_busy", busy, 0);
    `CHK("rst_err", err_wlast, 0);
    `CHK("rst_grant", grant, 0);
    `CHK("rst_m_awvalid", m_awvalid, 0);
    `CHK("rst_m_wvalid", m_wvalid, 0);
    `CHK("rst_m_bready", m_bready, 0);
    `CHK("rst_m_awaddr", m_awaddr, 0);
    `CHK("rst_m_wdata", m_wdata, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Simultaneous requests straight after reset, then two more alternating ties.
    tie_pair(12'h010, 4, 12'h020, 3);
    tie_pair(12'h030, 2, 12'h040, 5);
    tie_pair(12'h050, 1, 12'h060, 2);

    // Single master with one-cycle arbitration latency.
    xact(1'b0, 12'h12C, 4, 8'd3, 32'd1, 0, 1, -1);
    `CHK("mem_12c_0", mem[12'h12C], 1);
    `CHK("mem_12f_3", mem[12'h12F], 4);

    // W presented before AW, and the slave holds AW until all 64 beats are in.
    aw_late = 1'b1;
    xact(1'b1, 12'd300, 64, 8'd63, 32'd1, 5, 0, -1);
    aw_late = 1'b0;
    `CHK("wfirst_mem_last", mem[12'd363], 64);
    `CHK("wfirst_err", err_wlast, 0);

    for (int k = 0; k < 16; k++) begin
      mm = bit'($urandom_range(0, 1));
      tie_sel = ($urandom_range(0, 2) == 0);
      n = $urandom_range(1, 16);
      n2 = $urandom_range(1, 16);
      a = 12'($urandom_range(0, 4095));
      a2 = 12'($urandom_range(0, 4095));
      if (tie_sel) tie_pair(a, n, a2, n2);
      else xact(mm, a, n, 8'(n - 1), $urandom, $urandom_range(0, 3), 0, -1);
    end
    `CHK("random_err", err_wlast, 0);

    // wlast on the third beat of a four-beat burst: sticky error, normal completion.
    xact(1'b0, 12'h700, 3, 8'd3, 32'hA0, 0, 0, -1);
    `CHK("mismatch_err", err_wlast, 1);
    xact(1'b1, 12'h710, 2, 8'd1, 32'hB0, 0, 0, -1);
    `CHK("mismatch_err_sticky", err_wlast, 1);

    // Reset during beat 10 of a 64-beat master-1 burst.
    xact(1'b1, 12'h800, 64, 8'd63, 32'h1000, 0, 0, 10);
    @(negedge clk);
    #2;
    `CHK("midrst_busy", busy, 0);
    `CHK("midrst_m_awvalid", m_awvalid, 0);
    `CHK("midrst_m_wvalid", m_wvalid, 0);
    `CHK("midrst_grant", grant, 0);
    `CHK("midrst_err_cleared", err_wlast, 0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_last = 1'b1;
    @(negedge clk);
    xact(1'b0, 12'h900, 4, 8'd3, 32'h55, 0, 1, -1);
    `CHK("after_rst_err", err_wlast, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
